// File: rtl/msg_pkg.sv
// msg_pkg: shared widths, strip FSM states and padding mask/marker helpers
package msg_pkg;
  localparam int WORD_W = 512;
  localparam int SIZE_W = 64;
  localparam int REM_W = 9;
  localparam int CNT_W = SIZE_W - REM_W;
  typedef enum logic [2:0] {ST_EMPTY, ST_HELD, ST_DECIDE, ST_TAIL, ST_SIZE} state_t;
  function automatic logic [WORD_W-1:0] last_word_mask(input logic [REM_W-1:0] rem);
    logic [WORD_W-1:0] ones;
    ones = '1;
    return rem == '0 ? ones : ~(ones >> rem);
  endfunction
  function automatic logic [WORD_W-1:0] last_word_marker(input logic [REM_W-1:0] rem);
    return {1'b1, {(WORD_W-1){1'b0}}} >> rem;
  endfunction
  function automatic logic [CNT_W-1:0] size_to_words(input logic [SIZE_W-1:0] size);
    return size[SIZE_W-1:REM_W] + CNT_W'(|size[REM_W-1:0]);
  endfunction
endpackage

// File: rtl/msg_pad_check.sv
// msg_pad_check: validates terminator/padding layout and word count of a final padded word
module msg_pad_check import msg_pkg::*; (
  input  logic [WORD_W-1:0] i_word,
  input  logic [CNT_W-1:0]  i_m,
  output logic              o_err,
  output logic              o_in_word
);
  logic [REM_W-1:0] w_rem;
  logic [CNT_W-1:0] w_n;
  logic [WORD_W-1:0] w_mask, w_marker, w_body;
  logic w_pad_ok, w_cnt_ok;
  always_comb begin
    w_rem = i_word[REM_W-1:0];
    w_n = size_to_words(i_word[SIZE_W-1:0]);
    w_mask = last_word_mask(w_rem);
    w_marker = last_word_marker(w_rem);
    o_in_word = w_rem != '0 && w_rem < REM_W'(WORD_W - SIZE_W);
    // an extra word's marker lands below bit 64 unless rem==0, so one compare covers both layouts
    w_body = o_in_word ? i_word & ~w_mask : i_word;
    w_pad_ok = w_body[WORD_W-1:SIZE_W] == w_marker[WORD_W-1:SIZE_W];
    w_cnt_ok = i_m == (o_in_word ? w_n : w_n + 1'b1);
    o_err = !w_pad_ok || !w_cnt_ok || &i_m;
  end
endmodule

// File: rtl/message_strip.sv
// message_strip: strips padding from 512-bit blocks, emits masked payload words then the bit length
module message_strip import msg_pkg::*; (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_in_last,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic [WORD_W-1:0] data_out,
  output logic              data_out_last,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic [SIZE_W-1:0] size_out,
  output logic              size_err,
  output logic              size_out_valid,
  input  logic              size_out_ready
);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_m;
  logic [WORD_W-1:0] r_buf, r_last, w_mask, w_emit_data;
  logic r_err, w_free, w_acc, w_held, w_err, w_in_word, w_emit, w_emit_last, w_size_hs;
  msg_pad_check u_chk (.i_word(r_last), .i_m(r_m), .o_err(w_err), .o_in_word(w_in_word));
  assign w_free = !data_out_valid || data_out_ready;
  assign data_in_ready = !sync_rst && (r_state == ST_EMPTY || r_state == ST_HELD) && w_free;
  assign w_acc = data_in_valid && data_in_ready;
  assign w_held = |r_m[CNT_W-1:1];
  assign w_mask = last_word_mask(r_last[REM_W-1:0]);
  assign size_out = r_last[SIZE_W-1:0];
  assign size_err = r_err;
  assign size_out_valid = r_state == ST_SIZE && !data_out_valid;
  assign w_size_hs = size_out_valid && size_out_ready;
  always_ff @(posedge clk) begin
    if (sync_rst) r_state <= ST_EMPTY;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_EMPTY:  if (w_acc) w_next = data_in_last ? ST_DECIDE : ST_HELD;
      ST_HELD:   if (w_acc && data_in_last) w_next = ST_DECIDE;
      ST_DECIDE: if (w_free) w_next = (w_in_word && !w_err) ? ST_TAIL : ST_SIZE;
      ST_TAIL:   if (w_free) w_next = ST_SIZE;
      ST_SIZE:   if (w_size_hs) w_next = ST_EMPTY;
      default:   w_next = ST_EMPTY;
    endcase
  end
  always_comb begin
    w_emit = 1'b0;
    w_emit_last = 1'b0;
    w_emit_data = r_buf;
    case (r_state)
      ST_HELD: w_emit = w_acc && !data_in_last;
      ST_DECIDE: begin
        w_emit = w_free && w_held;
        w_emit_last = w_err || !w_in_word;
        w_emit_data = (w_err || w_in_word) ? r_buf : r_buf & w_mask;
      end
      ST_TAIL: begin
        w_emit = w_free;
        w_emit_last = 1'b1;
        w_emit_data = r_last & w_mask;
      end
      default: w_emit = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      data_out <= '0;
      data_out_last <= 1'b0;
      data_out_valid <= 1'b0;
      r_m <= '0;
      r_buf <= '0;
      r_last <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_emit) begin
        data_out <= w_emit_data;
        data_out_last <= w_emit_last;
        data_out_valid <= 1'b1;
      end else if (data_out_ready) data_out_valid <= 1'b0;
      if (w_acc) r_m <= &r_m ? r_m : r_m + 1'b1;
      if (w_acc && !data_in_last) r_buf <= data_in;
      if (w_acc && data_in_last) r_last <= data_in;
      if (r_state == ST_DECIDE && w_free) r_err <= w_err;
      if (w_size_hs) begin
        r_m <= '0;
        r_buf <= '0;
        r_err <= 1'b0;
      end
    end
  end
endmodule

// File: doc/message_strip.md
# message_strip

Receive-side counterpart of the message padding builder. Accepts a stream of padded 512-bit blocks, each message ending with a terminator bit and a 64-bit big-endian bit-length field. Recovers the original message words and the message length. Emits data words with the last word masked to the true bit length, then reports the size on a separate channel. Used for loopback checking and for consumers that need unpadded payloads.

## Interface
- No parameters. Widths are fixed: 512-bit word, 64-bit size, 9-bit remainder.
- clk  in  1  clock; all logic is on the rising edge.
- sync_rst  in  1  synchronous, active-high reset; the only reset.
- data_in  in  512  padded word; bit 511 is the first message bit.
- data_in_last  in  1  final padded word of the message; it carries size in [63:0].
- data_in_valid / data_in_ready  in / out  1  input handshake.
- data_out  out  512  recovered message word.
- data_out_last  out  1  final data word of the message.
- data_out_valid / data_out_ready  out / in  1  output handshake.
- size_out  out  64  recovered message length in bits.
- size_err  out  1  qualifies size_out: the padding or word count is inconsistent.
- size_out_valid / size_out_ready  out / in  1  size handshake.

## Operation
- Definitions, taken from the size field S = data_in[63:0] of the last input word:
  - rem = S[8:0]
  - N = S[63:9] + |rem (number of data words, 55 bits)
  - M = input words received, including the last word (55-bit counter)
- Valid layouts:
  - rem in 1..447: M==N. The last input word is the final data word. Bit (511-rem) must be 1, and bits below it down to bit 64 must be 0.
  - rem==0 or rem>=448: M==N+1. The last input word is an extra word with [511:64] all zero, except bit 511 = (rem==0).
  - Any mismatch sets size_err=1.
- Mask for the final data word keeps the top rem bits and zeroes the rest. If rem==0, the word passes unmasked.
- One word is always held in a buffer, because a word cannot be classified until its successor arrives.
- States:
  - EMPTY: no word held. On an accepted word that is not last → HELD. On an accepted last word → DECIDE.
  - HELD: on each accepted non-last word, emit the buffer (last=0), then reload the buffer. On an accepted last word → DECIDE.
  - DECIDE (one cycle; input not ready), selected by layout:
    - M==N with a word held: emit the held word (last=0), load the last input word into the buffer → TAIL.
    - M==N with nothing held (N==1): load the last input word → TAIL.
    - M==N+1 with N>=1: emit the held word masked, last=1 → SIZE.
    - M==N+1 with N==0 (S==0): emit no data → SIZE.
    - Error: emit the held word unmasked, last=1 if one is held → SIZE with size_err=1.
  - TAIL: emit the buffer masked, last=1 → SIZE.
  - SIZE: assert size_out_valid with S and the error flag. On handshake → EMPTY, with M and the buffer cleared.
- Every "emit" waits until the output register is free: !data_out_valid || data_out_ready.

## Timing
- Reset values:
  - data_in_ready=0, data_out=0, data_out_last=0, data_out_valid=0.
  - size_out=0, size_err=0, size_out_valid=0.
  - State=EMPTY, M=0, buffer=0.
- data_in_ready is combinational: (state EMPTY or HELD) && output register free. It is never high in DECIDE, TAIL or SIZE.
- data_out is a single register stage; valid stays high until ready. Full throughput is one word per cycle in HELD when data_out_ready=1.
- Latency: the first output appears one cycle after the second input handshake. The final data word appears 1–2 cycles after the last input handshake, stall-free.
- size_out_valid rises no earlier than the cycle in which the final data_out handshake completes. Downstream may hold size_out_ready low indefinitely, and input stays stalled meanwhile.
- Simultaneous output drain and new emit in the same cycle is legal and must not drop or duplicate a word.
- M saturates at all-ones and sets size_err.
- sync_rst mid-message discards the buffered word and any pending output on the next edge; no partial size is emitted.

## Structure
- Shared package msg_pkg:
  - WORD_W=512, SIZE_W=64, REM_W=9
  - state enum
  - function last_word_mask(rem)
  - function size_to_words(size)
- The builder's mask/marker logic moves into the same package functions.
- One natural sub-module, msg_pad_check: combinational layout and terminator validation that returns the error flag and the classification (in-word vs extra-word).

## Test plan
- 'abc' message (S=24): one word with data in the top 24 bits, bit 487 set, [63:0]=24 → one data_out with top 24 bits kept, rest 0, last=1; then size_out=24, size_err=0.
- S=512: two words (data word, then a word with bit 511 and 512 in [63:0]) → one unmasked data_out, last=1; size_out=512.
- S=0: single word 0x8000…0000 → no data_out; size_out=0, size_err=0.
- S=1000: three input words → two data_out words, the second keeping its top 488 bits, last=1 on the second only; size_out=1000.
- Backpressure: S=1536 with data_out_ready toggling 1010… and size_out_ready held low for 20 cycles → no loss or duplication, input stalled until the size handshake.
- Error plus reset: S=5000 in a single last word → size_err=1. A second message receives sync_rst after 2 words, then a clean S=24 message → only the clean outputs appear.
